audio_out_conditioner: RTL and testbench

AUDIO_OUT_CONDITIONER -- requirements
Module: audio_out_conditioner

---
 rtl/audio_out_conditioner_pkg.sv | 17 +
 rtl/audio_out_conditioner_dc_block_ch.sv | 38 +++
 rtl/audio_out_conditioner.sv | 198 +++++++++++++++++++
 tb/tb_audio_out_conditioner.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/audio_out_conditioner_pkg.sv
// Shared synth package: sample width and gain-FSM encoding common to the mixer
// and the output conditioner.
package audio_out_conditioner_pkg;

   localparam int A_WIDTH_DEF = 24;

   localparam int             G_W     = 9;
   localparam logic [G_W-1:0] G_UNITY = 9'd256;

   typedef enum logic [1:0] {
      MUTED     = 2'd0,
      RAMP_UP   = 2'd1,
      RUN       = 2'd2,
      RAMP_DOWN = 2'd3
   } ramp_state_t;

endpackage

// File: rtl/audio_out_conditioner_dc_block_ch.sv
// One-channel DC blocker, y = x - x1 + y1 - (y1 >>> DC_SHIFT), with the
// output register doubling as the y1 history.
module dc_block_ch
   import audio_out_conditioner_pkg::*;
#(
   parameter int A_WIDTH  = A_WIDTH_DEF,
   parameter int DC_SHIFT = 10
) (
   input  logic                      sCLK_XVXENVS,
   input  logic                      reset_data_N,
   input  logic                      i_vld,
   input  logic                      i_bypass,
   input  logic signed [A_WIDTH-1:0] i_x,
   output logic signed [A_WIDTH+1:0] o_y
);

   logic signed [A_WIDTH+1:0] r_x1;
   logic signed [A_WIDTH+1:0] r_y1;
   logic signed [A_WIDTH+1:0] w_xe;
   logic signed [A_WIDTH+1:0] w_y;

   assign w_xe = {{2{i_x[A_WIDTH-1]}}, i_x};
   // Bypass still primes the history so leaving bypass does not produce a step.
   assign w_y  = i_bypass ? w_xe : (w_xe - r_x1 + r_y1 - (r_y1 >>> DC_SHIFT));

   always_ff @(posedge sCLK_XVXENVS or negedge reset_data_N) begin
      if (!reset_data_N) begin
         r_x1 <= '0;
         r_y1 <= '0;
      end else if (i_vld) begin
         r_x1 <= w_xe;
         r_y1 <= w_y;
      end
   end

   assign o_y = r_y1;

endmodule

// File: rtl/audio_out_conditioner.sv
// Output conditioner: per-channel DC blocker, gain ramp for click-free mute
// and saturating clip into the output registers, 3-cycle latency, no stall.
module audio_out_conditioner
   import audio_out_conditioner_pkg::*;
#(
   parameter int A_WIDTH   = A_WIDTH_DEF,
   parameter int DC_SHIFT  = 10,
   parameter int RAMP_STEP = 1
) (
   input  logic                      sCLK_XVXENVS,
   input  logic                      reset_data_N,
   input  logic                      in_valid,
   input  logic signed [A_WIDTH-1:0] lsound_in,
   input  logic signed [A_WIDTH-1:0] rsound_in,
   input  logic                      mute,
   input  logic                      dc_bypass,
   input  logic                      clr_clip,
   output logic signed [A_WIDTH-1:0] lsound_out,
   output logic signed [A_WIDTH-1:0] rsound_out,
   output logic                      out_valid,
   output logic [7:0]                clip_cnt,
   output logic [1:0]                ramp_state
);

   localparam int Y_W = A_WIDTH + 2;
   localparam int P_W = Y_W + G_W + 1;
   localparam logic [G_W-1:0] G_FIRST = (RAMP_STEP >= 256) ? G_UNITY : G_W'(RAMP_STEP);
   localparam logic signed [P_W-1:0] P_MAX = {{(P_W-A_WIDTH+1){1'b0}}, {(A_WIDTH-1){1'b1}}};
   localparam logic signed [P_W-1:0] P_MIN = {{(P_W-A_WIDTH+1){1'b1}}, {(A_WIDTH-1){1'b0}}};

   // ---------------- gain FSM ----------------
   ramp_state_t    r_state;
   ramp_state_t    w_state_next;
   logic [G_W-1:0] r_g;
   logic [G_W-1:0] w_g_next;
   logic [31:0]    w_g_up_sum;
   logic [G_W-1:0] w_g_up;
   logic [G_W-1:0] w_g_dn;

   assign w_g_up_sum = 32'(r_g) + 32'(RAMP_STEP);
   assign w_g_up     = (w_g_up_sum >= 32'd256) ? G_UNITY : w_g_up_sum[G_W-1:0];
   assign w_g_dn     = (32'(r_g) <= 32'(RAMP_STEP)) ? '0 : (r_g - G_W'(RAMP_STEP));

   always_ff @(posedge sCLK_XVXENVS or negedge reset_data_N) begin
      if (!reset_data_N) begin
         r_state <= MUTED;
         r_g     <= '0;
      end else begin
         r_state <= w_state_next;
         r_g     <= w_g_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_g_next     = r_g;
      if (in_valid) begin
         case (r_state)
            MUTED: begin
               if (!mute) begin
                  w_g_next     = G_FIRST;
                  w_state_next = (G_FIRST == G_UNITY) ? RUN : RAMP_UP;
               end
            end
            RUN: begin
               if (mute) begin
                  w_g_next     = w_g_dn;
                  w_state_next = (w_g_dn == '0) ? MUTED : RAMP_DOWN;
               end else begin
                  w_g_next     = G_UNITY;
               end
            end
            default: begin
               // Either ramp reverses direction from the current g, no jump.
               if (mute) begin
                  w_g_next     = w_g_dn;
                  w_state_next = (w_g_dn == '0) ? MUTED : RAMP_DOWN;
               end else begin
                  w_g_next     = w_g_up;
                  w_state_next = (w_g_up == G_UNITY) ? RUN : RAMP_UP;
               end
            end
         endcase
      end
   end

   // ---------------- pipeline control ----------------
   logic           r_s1_vld;
   logic           r_s2_vld;
   logic           r_s3_vld;
   logic           r_out_vld;
   logic [G_W-1:0] r_s1_g;
   logic [G_W-1:0] r_s2_g;

   always_ff @(posedge sCLK_XVXENVS or negedge reset_data_N) begin
      if (!reset_data_N) begin
         r_s1_vld  <= 1'b0;
         r_s2_vld  <= 1'b0;
         r_s3_vld  <= 1'b0;
         r_out_vld <= 1'b0;
         r_s1_g    <= '0;
         r_s2_g    <= '0;
      end else begin
         r_s1_vld  <= in_valid;
         r_s2_vld  <= r_s1_vld;
         r_s3_vld  <= r_s2_vld;
         r_out_vld <= r_s3_vld;
         // The gain travels with its own sample so ramps stay sample-accurate.
         if (in_valid) r_s1_g <= w_g_next;
         if (r_s1_vld) r_s2_g <= r_s1_g;
      end
   end

   // ---------------- per-channel datapath ----------------
   logic signed [A_WIDTH-1:0] w_in  [2];
   logic signed [A_WIDTH-1:0] w_sat [2];
   logic [1:0]                w_clip;

   assign w_in[0] = lsound_in;
   assign w_in[1] = rsound_in;

   for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic signed [A_WIDTH-1:0] r_s1_x;
      logic signed [Y_W-1:0]     w_y;
      logic signed [P_W-1:0]     w_prod;
      logic signed [P_W-1:0]     r_s3_p;
      logic                      w_hi;
      logic                      w_lo;

      always_ff @(posedge sCLK_XVXENVS or negedge reset_data_N) begin
         if (!reset_data_N) begin
            r_s1_x <= '0;
         end else if (in_valid) begin
            r_s1_x <= w_in[gi];
         end
      end

      dc_block_ch #(
         .A_WIDTH  (A_WIDTH),
         .DC_SHIFT (DC_SHIFT)
      ) u_dc (
         .sCLK_XVXENVS (sCLK_XVXENVS),
         .reset_data_N (reset_data_N),
         .i_vld        (r_s1_vld),
         .i_bypass     (dc_bypass),
         .i_x          (r_s1_x),
         .o_y          (w_y)
      );

      // Product is registered full width before the clip to keep the
      // multiplier and the saturation compare in separate cycles.
      assign w_prod = w_y * $signed({1'b0, r_s2_g});

      always_ff @(posedge sCLK_XVXENVS or negedge reset_data_N) begin
         if (!reset_data_N) begin
            r_s3_p <= '0;
         end else if (r_s2_vld) begin
            r_s3_p <= w_prod >>> 8;
         end
      end

      assign w_hi       = (r_s3_p > P_MAX);
      assign w_lo       = (r_s3_p < P_MIN);
      assign w_clip[gi] = w_hi | w_lo;
      assign w_sat[gi]  = w_hi ? {1'b0, {(A_WIDTH-1){1'b1}}} :
                          w_lo ? {1'b1, {(A_WIDTH-1){1'b0}}} :
                                 r_s3_p[A_WIDTH-1:0];
   end

   // ---------------- output registers ----------------
   logic signed [A_WIDTH-1:0] r_lout;
   logic signed [A_WIDTH-1:0] r_rout;
   logic [7:0]                r_clip_cnt;

   always_ff @(posedge sCLK_XVXENVS or negedge reset_data_N) begin
      if (!reset_data_N) begin
         r_lout     <= '0;
         r_rout     <= '0;
         r_clip_cnt <= '0;
      end else begin
         if (r_s3_vld) begin
            r_lout <= w_sat[0];
            r_rout <= w_sat[1];
         end
         if (clr_clip)
            r_clip_cnt <= '0;
         else if (r_s3_vld && (|w_clip) && (r_clip_cnt != 8'hFF))
            r_clip_cnt <= r_clip_cnt + 8'd1;
      end
   end

   assign lsound_out = r_lout;
   assign rsound_out = r_rout;
   assign out_valid  = r_out_vld;
   assign clip_cnt   = r_clip_cnt;
   assign ramp_state = r_state;

endmodule

// File: tb/tb_audio_out_conditioner.sv
// Directed bench for audio_out_conditioner: gain ramps, DC blocker, clipping,
// back-to-back throughput and reset with a frame in flight.
module tb_audio_out_conditioner;

   localparam int AW = 24;

   logic                 clk       = 1'b0;
   logic                 rst_n     = 1'b0;
   logic                 in_valid  = 1'b0;
   logic                 mute      = 1'b0;
   logic                 dc_bypass = 1'b1;
   logic                 clr_clip  = 1'b0;
   logic signed [AW-1:0] l_in      = '0;
   logic signed [AW-1:0] r_in      = '0;
   logic signed [AW-1:0] l_out;
   logic signed [AW-1:0] r_out;
   logic                 out_valid;
   logic [7:0]           clip_cnt;
   logic [1:0]           ramp_state;

   int n_checks = 0;
   int n_fail   = 0;
   int n_frames = 0;

   always #5 clk = ~clk;

   audio_out_conditioner #(
      .A_WIDTH   (AW),
      .DC_SHIFT  (10),
      .RAMP_STEP (1)
   ) dut (
      .sCLK_XVXENVS (clk),
      .reset_data_N (rst_n),
      .in_valid     (in_valid),
      .lsound_in    (l_in),
      .rsound_in    (r_in),
      .mute         (mute),
      .dc_bypass    (dc_bypass),
      .clr_clip     (clr_clip),
      .lsound_out   (l_out),
      .rsound_out   (r_out),
      .out_valid    (out_valid),
      .clip_cnt     (clip_cnt),
      .ramp_state   (ramp_state)
   );

   task automatic check_eq(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One isolated frame: in_valid on edge N, out_valid must appear on N+3 only.
   task automatic send_frame(input logic signed [AW-1:0] l, input logic signed [AW-1:0] r,
                             input logic m, input logic byp, input bit chk,
                             input logic signed [63:0] el, input logic signed [63:0] er,
                             input int es, input string tag);
      @(negedge clk);
      l_in = l; r_in = r; mute = m; dc_bypass = byp; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_eq({tag, "_early"}, out_valid, 0);
      @(negedge clk);
      check_eq({tag, "_valid"}, out_valid, 1);
      n_frames++;
      $display("frame %0d %s: in %0d/%0d -> out %0d/%0d state %0d clip %0d",
               n_frames, tag, l, r, l_out, r_out, ramp_state, clip_cnt);
      if (chk) begin
         check_eq({tag, "_l"}, l_out, el);
         check_eq({tag, "_r"}, r_out, er);
         check_eq({tag, "_state"}, ramp_state, es);
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_l[4] = '{4096, 4092, 4089, 4086};
      int exp_r[4] = '{-4095, -4091, -4087, -4083};
      bit saw;

      // Reset values
      repeat (2) @(negedge clk);
      check_eq("rst_l", l_out, 0);
      check_eq("rst_r", r_out, 0);
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_clip", clip_cnt, 0);
      check_eq("rst_state", ramp_state, 0);
      rst_n = 1'b1;

      // Ramp up from mute, bypassed DC blocker: out = (x*k)>>>8 on frame k
      for (int k = 1; k <= 256; k++)
         send_frame(1000, -1000, 0, 1, 1, (1000 * k) >>> 8, (-1000 * k) >>> 8,
                    (k == 256) ? 2 : 1, $sformatf("ramp_up%0d", k));

      // Five back-to-back frames in RUN
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c >= 1 && c <= 3) check_eq($sformatf("burst_idle%0d", c), out_valid, 0);
         if (c >= 4 && c <= 8) begin
            check_eq($sformatf("burst_valid%0d", c), out_valid, 1);
            check_eq($sformatf("burst_l%0d", c), l_out, 100 * (c - 3));
            check_eq($sformatf("burst_r%0d", c), r_out, -100 * (c - 3));
            $display("burst out %0d/%0d", l_out, r_out);
         end
         if (c == 9) check_eq("burst_end", out_valid, 0);
         if (c < 5) begin
            in_valid = 1'b1; l_in = AW'(100 * (c + 1)); r_in = AW'(-100 * (c + 1));
         end else begin
            in_valid = 1'b0;
         end
      end
      repeat (3) @(negedge clk);
      check_eq("hold_l", l_out, 500);
      check_eq("hold_r", r_out, -500);

      // DC blocker decay at unity gain
      for (int i = 0; i < 4; i++)
         send_frame(4096, -4096, 0, 0, 1, exp_l[i], exp_r[i], 2, $sformatf("dc%0d", i));

      // Saturation and clip counting
      send_frame(0, 0, 0, 1, 1, 0, 0, 2, "sat_pre");
      send_frame(-8388608, 8388607, 0, 0, 1, -8388608, 8388607, 2, "sat_a");
      check_eq("sat_a_clip", clip_cnt, 0);
      send_frame(8388607, -8388608, 0, 0, 1, 8388607, -8388608, 2, "sat_b");
      check_eq("sat_b_clip", clip_cnt, 1);
      send_frame(8388607, -8388608, 0, 0, 1, 8388600, -8388599, 2, "sat_c");
      check_eq("sat_c_clip", clip_cnt, 1);
      @(negedge clk); clr_clip = 1'b1;
      @(negedge clk); clr_clip = 1'b0;
      check_eq("clr_clip", clip_cnt, 0);

      // 256 clipping frames: counter must stop at 255
      for (int i = 0; i < 256; i++) begin
         send_frame(-8388608, 0, 0, 1, 1, -8388608, 0, 2, $sformatf("cnt_a%0d", i));
         send_frame(8388607, 0, 0, 0, 1, 8388607, 0, 2, $sformatf("cnt_b%0d", i));
      end
      check_eq("clip_hold255", clip_cnt, 255);

      // Reset one cycle after in_valid: frame must vanish
      @(negedge clk);
      l_in = 777; r_in = 777; mute = 1'b0; dc_bypass = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; rst_n = 1'b0;
      saw = 1'b0;
      repeat (3) begin @(negedge clk); saw |= out_valid; end
      rst_n = 1'b1;
      repeat (6) begin @(negedge clk); saw |= out_valid; end
      check_eq("flight_no_valid", saw, 0);
      check_eq("flight_l", l_out, 0);
      check_eq("flight_r", r_out, 0);
      check_eq("flight_clip", clip_cnt, 0);
      check_eq("flight_state", ramp_state, 0);
      send_frame(1000, 1000, 1, 1, 1, 0, 0, 0, "post_rst_g0");

      // Mute during ramp-up at g=100
      for (int k = 1; k <= 100; k++)
         send_frame(1000, -1000, 0, 1, 1, (1000 * k) >>> 8, (-1000 * k) >>> 8, 1,
                    $sformatf("up%0d", k));
      for (int m = 1; m <= 100; m++)
         send_frame(1000, -1000, 1, 1, 1, (1000 * (100 - m)) >>> 8, (-1000 * (100 - m)) >>> 8,
                    (m == 100) ? 0 : 3, $sformatf("down%0d", m));
      for (int i = 0; i < 3; i++)
         send_frame(1000, -1000, 1, 1, 1, 0, 0, 0, $sformatf("muted%0d", i));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
